// File: rtl/nioshello_onchip_mem_stream_reader.sv
// Avalon-MM read master for the on-chip memory s1 port. It streams word_count
// consecutive words out as a single Avalon-ST packet, with ready/valid backpressure.
module nioshello_onchip_mem_stream_reader #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 17,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  word_count,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_sop,
    output logic              st_eop
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  issued;
    logic [LEN_W-1:0]  sent;
    logic              inflight;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;

    logic             issue;
    logic             push;
    logic             pop;
    logic             last_beat;
    logic [CNT_W-1:0] credit_used;

    // Reserving a slot for the read in flight keeps the FIFO from ever overflowing,
    // even though the memory gives no way to stall a read that has already been issued.
    assign credit_used = fifo_count + CNT_W'(inflight);
    assign issue       = (state == RUN) && !abort && (issued < len)
                         && (credit_used < CNT_W'(FIFO_DEPTH));
    assign push        = inflight;
    assign pop         = st_valid && st_ready;
    assign last_beat   = pop && (sent == len - LEN_W'(1));

    assign mem_chipselect = issue;
    assign mem_address    = issue ? base + ADDR_W'(issued) : '0;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;

    assign st_valid = (fifo_count != '0);
    assign st_data  = fifo_mem[rd_ptr];
    assign st_sop   = st_valid && (sent == '0);
    assign st_eop   = st_valid && (sent == len - LEN_W'(1));

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_readdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            base       <= '0;
            len        <= '0;
            issued     <= '0;
            sent       <= '0;
            inflight   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (abort) begin
            // Dropping inflight discards the read that is still returning from memory.
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            inflight   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            done       <= 1'b0;
            inflight   <= issue;
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            if (issue) begin
                issued <= issued + LEN_W'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                sent   <= sent + LEN_W'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (word_count != '0) begin
                            state  <= RUN;
                            busy   <= 1'b1;
                            base   <= base_addr;
                            len    <= word_count;
                            issued <= '0;
                            sent   <= '0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issued == len) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_beat) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
